mc_mdu: RTL and testbench
=========================

Name: mc_mdu

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers for the multicycle MIPS core.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles; the control FSM stalls on `busy`.
- Also services MTHI/MTLO writes. HI/LO are read combinationally (MFHI/MFLO).

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits. Must be ≥4 and even.
CW, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk     input   1      clock; all state updates on rising edge
rst     input   1      reset, asynchronous, active-low
start   input   1      launch operation; sampled only in IDLE
op      input   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a       input   WIDTH  multiplicand / dividend (rs)
b       input   WIDTH  multiplier / divisor (rt)
cancel  input   1      abort in-flight operation
hi_we   input   1      MTHI write strobe
lo_we   input   1      MTLO write strobe
wdata   input   WIDTH  MTHI/MTLO data
busy    output  1      operation in flight
done    output  1      one-cycle pulse; new HI/LO visible this cycle
hi      output  WIDTH  HI register
lo      output  WIDTH  LO register

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Applies mid-operation; the partial result is discarded.
- States:
  - IDLE: on start=1, latch op, |a|, |b| (absolute values for signed ops; raw operands for unsigned), result signs, and divide-by-zero flag (b==0). Counter=WIDTH; go CALC.
  - CALC: one iteration per cycle; counter decrements. When counter reaches 1 at an edge, go FIX.
  - FIX: apply sign correction; write hi/lo; go IDLE. done=1 in the cycle after the FIX edge; busy=0 in that cycle.
- Latency: start sampled at edge E0. busy=1 from E0 to E(WIDTH+1). hi/lo are updated at E(WIDTH+1), and done is high for exactly that one following cycle.
- Multiply: shift-add on a 2·WIDTH accumulator; one multiplier bit per cycle. {hi,lo}=product.
  - MULT: negate the 2·WIDTH result if operand signs differ.
- Divide: restoring division; one quotient bit per cycle. lo=quotient, hi=remainder.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - Signed overflow MININT/−1: lo=MININT, hi=0. This falls out naturally from the unsigned datapath.
- Divide by zero (DIVU and DIV): hi=a (original operand), lo=all ones. Full latency is still used.
- start while busy: ignored; no queueing.
- cancel: in CALC or FIX → IDLE next edge; hi/lo unchanged; done not pulsed. Ignored in IDLE.
- hi_we/lo_we:
  - In IDLE: write wdata at the edge.
  - Ignored while busy; the core must stall.
  - If start and hi_we/lo_we occur in the same IDLE cycle, the write takes effect and the result later overwrites it.
- cancel has priority over FIX completion in the same cycle.
- op is ignored unless start=1 in IDLE.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU compute the full product with a single-cycle multiplier in one CALC cycle (counter loaded with 1). Multiply latency: busy from E0 to E2, done in the cycle after E2. Divide is unchanged. Signed fixup still occurs in FIX.
- Undefined: all operations take WIDTH+1 edges, with no hardware multiplier inferred.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after start; busy high throughout.
- MULT a=0xFFFFFFFD (−3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21).
- DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 → lo=14, hi=2.
- DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=5 b=0 → hi=5, lo=0xFFFFFFFF.
- hi_we with wdata=0x1234 in IDLE → hi=0x1234. Then start MULTU 6×7; second start at cycle 5 ignored; cancel at cycle 10 → busy=0 next cycle, hi=0x1234, done never asserted.
- rst pulsed low mid-CALC → busy=0, done=0, hi=lo=0 immediately (before next clk edge). A new start after release completes normally.

Source files
------------

// File: rtl/mc_mdu.sv
// mc_mdu -- iterative multiply/divide unit with HI/LO registers.
//
// Executes MULTU/MULT/DIVU/DIV on WIDTH-bit operands over WIDTH+1 clock
// edges (shift-add multiply, restoring divide, one bit per cycle). Signed
// operations run on absolute values; the signs are reapplied in a final
// FIX cycle. HI/LO are also writable directly (MTHI/MTLO) while idle and
// are read combinationally (MFHI/MFLO).
//
// Optional build macro: MDU_FAST_MUL_EN
//   defined   -> MULT/MULTU use a single-cycle multiplier (one CALC cycle)
//   undefined -> every operation is iterative; no multiplier is inferred
//
// Ports:
//   clk     clock, all state updates on the rising edge
//   rst     asynchronous active-low reset
//   start   launch an operation (sampled only while idle)
//   op      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b    rs / rt operands
//   cancel  abort an in-flight operation, HI/LO untouched
//   hi_we   MTHI write strobe (idle only)
//   lo_we   MTLO write strobe (idle only)
//   wdata   MTHI/MTLO data
//   busy    operation in flight
//   done    one-cycle pulse, new HI/LO visible in this cycle
//   hi, lo  HI / LO registers
module mc_mdu #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  // Multiply: {partial product high, multiplier bits still to consume}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;   // multiplicand or divisor (absolute value)
  logic               is_div_reg;
  logic               neg_q_reg;  // negate product / quotient
  logic               neg_r_reg;  // negate remainder (dividend sign)
  logic               div0_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;

  // ---------------- launch decode ----------------
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [CW-1:0]    launch_cnt;

  assign op_div = op[1];
  assign a_neg  = op[0] & a[WIDTH-1];
  assign b_neg  = op[0] & b[WIDTH-1];
  // MININT maps onto itself, which read as unsigned is its true magnitude.
  assign a_abs  = a_neg ? -a : a;
  assign b_abs  = b_neg ? -b : b;

`ifdef MDU_FAST_MUL_EN
  assign launch_cnt = op_div ? CW'(WIDTH) : CW'(1);
`else
  assign launch_cnt = CW'(WIDTH);
`endif

  // ---------------- iteration datapath ----------------
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;

`ifdef MDU_FAST_MUL_EN
  always_comb begin
    mul_next = {{WIDTH{1'b0}}, opnd_reg} * {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]};
  end
`else
  logic [WIDTH:0] mul_sum;

  // Add the multiplicand when the current multiplier bit is set, then shift
  // the whole accumulator right; the carry lands in the top bit.
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
             + {1'b0, (acc_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
  end
`endif

  // Restoring divide step: shift the next dividend bit into the remainder
  // and try to subtract. Bit WIDTH of the difference is the borrow, because
  // the shifted remainder is always below twice the divisor.
  always_comb begin
    rem_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, opnd_reg};
    if (rem_diff[WIDTH]) begin
      div_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {rem_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end
    acc_next = is_div_reg ? div_next : mul_next;
  end

  // ---------------- sign fix-up ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // With a zero divisor the remainder already equals |a|, so the ordinary
  // remainder sign rule restores the original a; only LO needs forcing.
  always_comb begin
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    quot     = acc_reg[WIDTH-1:0];
    rem      = acc_reg[2*WIDTH-1:WIDTH];
    quot_fix = div0_reg ? {WIDTH{1'b1}} : (neg_q_reg ? -quot : quot);
    rem_fix  = neg_r_reg ? -rem : rem;
    fix_hi   = is_div_reg ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = is_div_reg ? quot_fix : prod_fix[WIDTH-1:0];
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (hi_we) hi_reg <= wdata;
          if (lo_we) lo_reg <= wdata;
          if (start) begin
            is_div_reg <= op_div;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            div0_reg   <= op_div & (b == '0);
            cnt_reg    <= launch_cnt;
            if (op_div) begin
              acc_reg  <= {{WIDTH{1'b0}}, a_abs};
              opnd_reg <= b_abs;
            end else begin
              acc_reg  <= {{WIDTH{1'b0}}, b_abs};
              opnd_reg <= a_abs;
            end
            state_reg <= S_CALC;
          end
        end
        S_CALC: begin
          if (cancel) begin
            state_reg <= S_IDLE;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          // cancel wins over completion in the same cycle
          if (!cancel) begin
            hi_reg   <= fix_hi;
            lo_reg   <= fix_lo;
            done_reg <= 1'b1;
          end
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_reg != S_IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mc_mdu.sv
// Testbench for mc_mdu (WIDTH=32): directed vectors with literal expected
// values plus a transaction-level reference model compared every cycle.
module tb_mc_mdu;

  localparam int W = 32;

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic         start  = 1'b0;
  logic [1:0]   op     = 2'd0;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic         cancel = 1'b0;
  logic         hi_we  = 1'b0;
  logic         lo_we  = 1'b0;
  logic [W-1:0] wdata  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mc_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Result {hi,lo} straight from the arithmetic definition of each op.
  function automatic logic [63:0] ref_calc(input logic [1:0] f_op,
                                           input logic [31:0] fa,
                                           input logic [31:0] fb);
    logic [63:0] r;
    longint sa, sb, q, rm;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    r  = '0;
    case (f_op)
      2'd0: r = {32'b0, fa} * {32'b0, fb};
      2'd1: r = sa * sb;
      2'd2: begin
        if (fb == 0) r = {fa, 32'hFFFF_FFFF};
        else         r = {fa % fb, fa / fb};
      end
      default: begin
        if (fb == 0) r = {fa, 32'hFFFF_FFFF};
        else begin
          q  = sa / sb;   // truncating division in 64 bits: MININT/-1 is exact
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Edges from the start edge to the edge that updates HI/LO.
  function automatic int lat(input logic [1:0] f_op);
`ifdef MDU_FAST_MUL_EN
    return f_op[1] ? W + 1 : 2;
`else
    return (f_op == 2'd0) ? W + 1 : W + 1;
`endif
  endfunction

  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_res  = '0;
  int          m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (cancel) m_busy = 1'b0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            {m_hi, m_lo} = m_res;
          end
        end
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start) begin
          m_busy = 1'b1;
          m_res  = ref_calc(op, a, b);
          m_left = lat(op);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_hi",   64'(hi),   64'(m_hi));
      chk("cyc_lo",   64'(lo),   64'(m_lo));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input logic [1:0] t_op, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input string nm);
    int n;
    bit got;
    chk({nm, "_model"}, ref_calc(t_op, ta, tb), {e_hi, e_lo});
    @(posedge clk); #1;
    start = 1'b1; op = t_op; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy0"}, 64'(busy), 64'd1);
    n = 0; got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
    chk({nm, "_timeout"}, 64'(got), 64'd1);
    chk({nm, "_latency"}, 64'(n), 64'(lat(t_op)));
    chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({nm, "_hi"}, 64'(hi), 64'(e_hi));
    chk({nm, "_lo"}, 64'(lo), 64'(e_lo));
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h edges=%0d", nm, t_op, ta, tb, hi, lo, n);
  endtask

  initial begin
    int n;
    int pulses;
    bit got;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    cmp_en = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minint");
    run_op(2'd0, 32'd6,         32'd7,         32'd0,         32'd42,        "multu_small");
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_negdiv");
    run_op(2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        "divu");
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf");
    run_op(2'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");
    run_op(2'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "divu_zero");

    // MTHI / MTLO while idle
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi", 64'(hi), 64'h1234);
    lo_we = 1'b1; wdata = 32'h5678;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mtlo", 64'(lo), 64'h5678);
    $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);

    // MULTU 6x7, ignored second start, ignored MTHI, cancel at cycle 10
    start = 1'b1; op = 2'd0; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;                    // E0
    start = 1'b0;
    repeat (4) @(posedge clk); #1;         // after E4
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;                    // E5
    start = 1'b0;
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk); #1;                    // E6
    hi_we = 1'b0;
    repeat (3) @(posedge clk); #1;         // after E9
    cancel = 1'b1;
    @(posedge clk); #1;                    // E10
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_hi",   64'(hi),   64'h1234);
    chk("cancel_lo",   64'(lo),   64'h5678);
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("cancel_no_done", 64'(pulses), 64'd0);
    chk("cancel_idle",    64'(busy),   64'd0);
    $display("cancel -> hi=%h lo=%h done_pulses=%0d", hi, lo, pulses);

    // start and MTHI in the same idle cycle: write now, result overwrites later
    start = 1'b1; op = 2'd0; a = 32'd6; b = 32'd7; hi_we = 1'b1; wdata = 32'hAAAA;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    chk("same_cyc_hi", 64'(hi), 64'hAAAA);
    n = 0; got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
    chk("same_cyc_timeout", 64'(got), 64'd1);
    chk("same_cyc_res_hi",  64'(hi),  64'd0);
    chk("same_cyc_res_lo",  64'(lo),  64'd42);
    $display("start+mthi -> hi=%h lo=%h edges=%0d", hi, lo, n);

    // leave non-zero HI/LO, then reset in the middle of CALC
    run_op(2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "pre_reset");
    @(posedge clk); #1;
    start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi",   64'(hi),   64'd0);
    chk("arst_lo",   64'(lo),   64'd0);
    $display("async reset -> busy=%0b hi=%h lo=%h", busy, hi, lo);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "post_reset");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
